// File: rtl/main_control_fsm_if.sv
// Control bundle between the multicycle main control FSM and the MIPS datapath.
// master = control unit side, slave = datapath / observer side.
interface main_control_fsm_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic [5:0]       opcode;
  logic             mem_ready;

  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             IRWrite;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;

  logic [3:0]       state;
  logic             instr_done;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, instr_done, illegal_op, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, instr_done, illegal_op, instr_count
  );
endinterface

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control unit: Moore FSM sequencing fetch/decode/execute/
// memory/write-back, with retirement counting and illegal-opcode reporting.
module main_control_fsm #(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  main_control_fsm_if.master bus
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] JUMP   = 4'd9;
  localparam logic [3:0] ADDIEX = 4'd10;
  localparam logic [3:0] ADDIWB = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [3:0]       state_q;
  logic [3:0]       state_d;
  logic [5:0]       op_q;
  logic             done_q;
  logic             ill_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  logic             illegal;

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, memtoreg;
  logic       ir_write, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;

  // Next state, plus the retire/illegal events qualified by the transition taken.
  always_comb begin
    state_d = FETCH;
    retire  = 1'b0;
    illegal = 1'b0;
    case (state_q)
      FETCH:  state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (op_q == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = bus.mem_ready ? MEMWB : MEMRD;
      MEMWB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      MEMWR: begin
        if (bus.mem_ready) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else begin
          state_d = MEMWR;
        end
      end
      EXEC:   state_d = ALUWB;
      ALUWB, BRANCH, JUMP, ADDIWB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      ADDIEX: state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      op_q    <= '0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        op_q <= bus.opcode;
      end
      done_q <= retire;
      ill_q  <= illegal;
      if (retire) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Moore decode of datapath controls; FETCH strobes follow mem_ready.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    memtoreg      = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
      end
      DECODE: alu_src_b = 2'b11;
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write = 1'b1;
        memtoreg  = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      ADDIWB: reg_write = 1'b1;
      default: ;
    endcase
  end

  // Write strobes are gated by rst_n directly so no strobe escapes while reset
  // is asserted, independent of the async state clear.
  assign bus.PCWrite     = pc_write      & rst_n;
  assign bus.PCWriteCond = pc_write_cond & rst_n;
  assign bus.IRWrite     = ir_write      & rst_n;
  assign bus.RegWrite    = reg_write     & rst_n;
  assign bus.MemWrite    = mem_write     & rst_n;
  assign bus.IorD        = iord;
  assign bus.MemRead     = mem_read;
  assign bus.MemtoReg    = memtoreg;
  assign bus.RegDst      = reg_dst;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ALUOp       = alu_op;
  assign bus.PCSource    = pc_source;

  assign bus.state       = state_q;
  assign bus.instr_done  = done_q;
  assign bus.illegal_op  = ill_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: per-cycle expected state/controls/pulses/count
// are queued when stimulus is driven and checked against the DUT mid-cycle.
module tb_main_control_fsm;
  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  main_control_fsm_if #(.CNT_W(CNT_W)) bus ();

  main_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       st;
    logic [15:0]      ctrl;
    logic             done;
    logic             ill;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  int               tests = 0;
  int               fails = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  // Control word {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,
  // RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource} expected for a state.
  function automatic logic [15:0] ctrl_of(input logic [3:0] s, input logic mr, input logic rn);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rwr, asa;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rwr, asa} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (s)
      S_FETCH:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE: asb = 2'b11;
      S_MEMADR: begin asa = 1'b1; asb = 2'b10; end
      S_MEMRD:  begin mrd = 1'b1; iord = 1'b1; end
      S_MEMWB:  begin rwr = 1'b1; m2r = 1'b1; end
      S_MEMWR:  begin mwr = 1'b1; iord = 1'b1; end
      S_EXEC:   begin asa = 1'b1; aop = 2'b10; end
      S_ALUWB:  begin rwr = 1'b1; rdst = 1'b1; end
      S_BRANCH: begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      S_JUMP:   begin pcw = 1'b1; pcs = 2'b10; end
      S_ADDIEX: begin asa = 1'b1; asb = 2'b10; end
      S_ADDIWB: rwr = 1'b1;
      default: ;
    endcase
    if (!rn) begin
      pcw = 1'b0; pcwc = 1'b0; irw = 1'b0; rwr = 1'b0; mwr = 1'b0;
    end
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rwr, asa, asb, aop, pcs};
  endfunction

  function automatic logic [15:0] obs_ctrl();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.MemtoReg, bus.IRWrite, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOp, bus.PCSource};
  endfunction

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cycle(input logic [3:0] es, input logic ed, input logic ei);
    exp_t e;
    if (ed) exp_cnt = exp_cnt + CNT_W'(1);
    e.st   = es;
    e.ctrl = ctrl_of(es, bus.mem_ready, rst_n);
    e.done = ed;
    e.ill  = ei;
    e.cnt  = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      cmp({tag, ".state"}, {12'd0, bus.state}, {12'd0, e.st});
      cmp({tag, ".ctrl"}, obs_ctrl(), e.ctrl);
      cmp({tag, ".done"}, {15'd0, bus.instr_done}, {15'd0, e.done});
      cmp({tag, ".ill"}, {15'd0, bus.illegal_op}, {15'd0, e.ill});
      cmp({tag, ".cnt"}, {12'd0, bus.instr_count}, {12'd0, e.cnt});
    end
  endtask

  task automatic step(input logic mr, input logic [5:0] op, input logic [3:0] es,
                      input logic ed, input logic ei, input string tag);
    bus.mem_ready = mr;
    bus.opcode    = op;
    expect_cycle(es, ed, ei);
    #1;
    check(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.mem_ready = 1'b1;
    bus.opcode    = OP_BAD;
    rst_n         = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, OP_BAD, S_FETCH, 1'b0, 1'b0, "reset_hold0");
    step(1'b1, OP_BAD, S_FETCH, 1'b0, 1'b0, "reset_hold1");
    rst_n = 1'b1;

    // j immediately after reset release; first FETCH writes PC/IR
    step(1'b1, OP_BAD, S_FETCH,  1'b0, 1'b0, "first_fetch");
    step(1'b1, OP_J,   S_DECODE, 1'b0, 1'b0, "j_dec");
    step(1'b0, OP_BAD, S_JUMP,   1'b0, 1'b0, "j_jump");

    // lw with 2 FETCH stalls and 1 MEMRD stall
    step(1'b0, OP_BAD, S_FETCH,  1'b1, 1'b0, "lw_f0");
    step(1'b0, OP_BAD, S_FETCH,  1'b0, 1'b0, "lw_f1");
    step(1'b1, OP_BAD, S_FETCH,  1'b0, 1'b0, "lw_f2");
    step(1'b1, OP_LW,  S_DECODE, 1'b0, 1'b0, "lw_dec");
    step(1'b1, OP_BAD, S_MEMADR, 1'b0, 1'b0, "lw_adr");
    step(1'b0, OP_BAD, S_MEMRD,  1'b0, 1'b0, "lw_rd0");
    step(1'b1, OP_BAD, S_MEMRD,  1'b0, 1'b0, "lw_rd1");
    step(1'b0, OP_BAD, S_MEMWB,  1'b0, 1'b0, "lw_wb");

    // R-type then beq back-to-back
    step(1'b1, OP_BAD, S_FETCH,  1'b1, 1'b0, "r_fetch");
    step(1'b1, OP_R,   S_DECODE, 1'b0, 1'b0, "r_dec");
    step(1'b0, OP_BAD, S_EXEC,   1'b0, 1'b0, "r_exec");
    step(1'b1, OP_BAD, S_ALUWB,  1'b0, 1'b0, "r_wb");
    step(1'b1, OP_BAD, S_FETCH,  1'b1, 1'b0, "beq_fetch");
    step(1'b1, OP_BEQ, S_DECODE, 1'b0, 1'b0, "beq_dec");
    step(1'b1, OP_BAD, S_BRANCH, 1'b0, 1'b0, "beq_br");

    // illegal opcode: DECODE -> FETCH, pulse, no count
    step(1'b1, OP_BAD, S_FETCH,  1'b1, 1'b0, "ill_fetch");
    step(1'b1, OP_BAD, S_DECODE, 1'b0, 1'b0, "ill_dec");

    // addi
    step(1'b1, OP_BAD, S_FETCH,  1'b0, 1'b1, "addi_fetch");
    step(1'b1, OP_ADDI, S_DECODE, 1'b0, 1'b0, "addi_dec");
    step(1'b1, OP_BAD, S_ADDIEX, 1'b0, 1'b0, "addi_ex");
    step(1'b1, OP_BAD, S_ADDIWB, 1'b0, 1'b0, "addi_wb");

    // sw completing
    step(1'b1, OP_BAD, S_FETCH,  1'b1, 1'b0, "sw_fetch");
    step(1'b1, OP_SW,  S_DECODE, 1'b0, 1'b0, "sw_dec");
    step(1'b1, OP_BAD, S_MEMADR, 1'b0, 1'b0, "sw_adr");
    step(1'b1, OP_BAD, S_MEMWR,  1'b0, 1'b0, "sw_wr");

    // sw aborted by reset while stalled in MEMWR
    step(1'b1, OP_BAD, S_FETCH,  1'b1, 1'b0, "sw2_fetch");
    step(1'b1, OP_SW,  S_DECODE, 1'b0, 1'b0, "sw2_dec");
    step(1'b1, OP_BAD, S_MEMADR, 1'b0, 1'b0, "sw2_adr");
    bus.mem_ready = 1'b0;
    expect_cycle(S_MEMWR, 1'b0, 1'b0);
    #1;
    check("sw2_wr");
    rst_n   = 1'b0;
    exp_cnt = '0;
    expect_cycle(S_FETCH, 1'b0, 1'b0);
    #1;
    check("sw2_rst");
    @(posedge clk);
    #1;
    step(1'b1, OP_BAD, S_FETCH, 1'b0, 1'b0, "sw2_rst_hold");
    rst_n = 1'b1;

    // 16 jumps with a 4-bit counter: wraps back to 0
    for (int i = 0; i < 16; i++) begin
      step(1'b1, OP_BAD, S_FETCH,  (i > 0), 1'b0, "wrap_fetch");
      step(1'b1, OP_J,   S_DECODE, 1'b0,    1'b0, "wrap_dec");
      step(1'b1, OP_BAD, S_JUMP,   1'b0,    1'b0, "wrap_jump");
    end
    step(1'b0, OP_BAD, S_FETCH, 1'b1, 1'b0, "wrap_end");
    step(1'b0, OP_BAD, S_FETCH, 1'b0, 1'b0, "wrap_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
